// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: FSM states and serial CRC-8 step shared by the ccff chain loader.
package ccff_loader_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_e;
   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
      return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
   endfunction
endpackage

// File: rtl/ccff_crc8_serial.sv
// ccff_crc8_serial: bit-serial MSB-first CRC-8 accumulator with synchronous clear.
module ccff_crc8_serial
   import ccff_loader_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [7:0] crc_o
);
   logic [7:0] crc_q;
   always_ff @(posedge clk_i)
      if (rst_i || clr_i) crc_q <= CRC8_INIT;
      else if (en_i) crc_q <= crc8_step(crc_q, bit_i);
   assign crc_o = crc_q;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words into a ccff chain, then recirculates it once to CRC-check integrity.
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 31,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              abort,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              config_enable,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  bit_count
);
   localparam int LW = $clog2(WORD_W + 1);
   state_e            state_q, state_d;
   logic [WORD_W-1:0] sbuf_q, sbuf_d;
   logic [LW-1:0]     left_q, left_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [7:0]        crc_in, crc_out;
   logic              in_load, in_ver, empty, shift, last, clr;
   assign in_load       = state_q == LOAD;
   assign in_ver        = state_q == VERIFY;
   assign empty         = left_q == '0;
   assign shift         = in_load && !empty && !abort;
   assign last          = cnt_q == CNT_W'(CHAIN_LEN - 1);
   assign clr           = state_q == IDLE && start;
   assign word_ready    = in_load && empty && !abort;
   assign config_enable = shift || (in_ver && !abort);
   assign ccff_head     = in_ver ? ccff_tail : shift && sbuf_q[WORD_W-1];
   assign busy          = state_q != IDLE;
   assign done          = state_q == DONE;
   assign error         = err_q;
   assign bit_count     = cnt_q;
   always_comb begin
      state_d = state_q;
      sbuf_d  = sbuf_q;
      left_d  = left_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            err_d   = 1'b0;
            cnt_d   = '0;
            left_d  = '0;
         end
         LOAD: if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
         end else if (word_valid && word_ready) begin
            sbuf_d = word_data;
            left_d = LW'(WORD_W);
         end else if (shift) begin
            sbuf_d = sbuf_q << 1;
            left_d = left_q - LW'(1);
            cnt_d  = cnt_q + CNT_W'(1);
            // surplus low bits of the final word are dropped here
            if (last) begin
               state_d = VERIFY;
               cnt_d   = '0;
               left_d  = '0;
            end
         end
         VERIFY: if (abort) begin
            state_d = DONE;
            err_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            // fold the final tail bit in now so error is valid alongside done
            if (last) begin
               state_d = DONE;
               err_d   = err_q | (crc8_step(crc_out, ccff_tail) != crc_in);
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge prog_clk)
      if (pReset) begin
         state_q <= IDLE;
         sbuf_q  <= '0;
         left_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sbuf_q  <= sbuf_d;
         left_q  <= left_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   ccff_crc8_serial u_crc_in (
      .clk_i (prog_clk),
      .rst_i (pReset),
      .clr_i (clr),
      .en_i  (shift),
      .bit_i (sbuf_q[WORD_W-1]),
      .crc_o (crc_in)
   );
   ccff_crc8_serial u_crc_out (
      .clk_i (prog_clk),
      .rst_i (pReset),
      .clr_i (clr),
      .en_i  (in_ver && !abort),
      .bit_i (ccff_tail),
      .crc_o (crc_out)
   );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: drives two loaders (31-bit and 1-bit chains) against a behavioural ccff chain.
module tb_ccff_chain_loader;
   localparam int L = 31, W = 8, CW = 16;
   logic prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;
   logic pReset = 1'b1, start = 1'b0, abort = 1'b0, word_valid = 1'b0;
   logic [W-1:0] word_data = '0;
   logic word_ready, config_enable, ccff_head, ccff_tail, busy, done, error;
   logic [CW-1:0] bit_count;
   logic [L-1:0] chain = '0;
   logic fault = 1'b0;
   logic start1 = 1'b0, abort1 = 1'b0, valid1 = 1'b0;
   logic [W-1:0] data1 = 8'h80;
   logic ready1, en1, head1, busy1, done1, err1;
   logic [CW-1:0] cnt1;
   logic chain1 = 1'b0;
   int passed = 0, total = 0;
   logic [7:0] wq[4];
   int gq[4];
   int abort_cyc = -1, rst_cyc = -1, done_cyc, en_cnt;
   bit spam = 0;
   logic en_abort, err_done, err_c1;

   ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(CW)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
      .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
      .config_enable(config_enable), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
      .busy(busy), .done(done), .error(error), .bit_count(bit_count));
   ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(W), .CNT_W(CW)) dut1 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start1), .abort(abort1),
      .word_valid(valid1), .word_data(data1), .word_ready(ready1),
      .config_enable(en1), .ccff_head(head1), .ccff_tail(chain1),
      .busy(busy1), .done(done1), .error(err1), .bit_count(cnt1));

   // behavioural chain: head enters bit 0, tail leaves from the top; optional stuck-at-0 on bit 10
   assign ccff_tail = chain[L-1];
   always @(posedge prog_clk) begin
      if (config_enable) chain <= {chain[L-2:0], ccff_head} & ~(fault ? (L'(1) << 10) : L'(0));
      if (en1) chain1 <= head1;
   end

   function automatic logic [L-1:0] exp_chain();
      logic [31:0] cat;
      cat = {wq[0], wq[1], wq[2], wq[3]};
      return cat[31:32-L];
   endfunction

   task automatic drive(input int budget);
      int idx, wt;
      bit acc;
      idx = 0; wt = 0; done_cyc = -1; en_cnt = 0; en_abort = 1'b1; err_done = 1'b0; err_c1 = 1'bx;
      @(negedge prog_clk);
      for (int c = 0; c < budget; c++) begin
         start  = (c == 0) || (spam && c >= 5 && c <= 20 && c % 3 == 0);
         abort  = (c == abort_cyc);
         pReset = (c == rst_cyc);
         #1;
         word_valid = 1'b0;
         if (word_ready && idx < 4) begin
            if (wt < gq[idx]) wt++;
            else begin
               word_valid = 1'b1;
               word_data  = wq[idx];
            end
         end
         #1;
         acc = word_valid && word_ready;
         if (config_enable) en_cnt++;
         if (c == abort_cyc) en_abort = config_enable;
         if (c == 1) err_c1 = error;
         if (done) begin
            done_cyc = c;
            err_done = error;
         end
         @(negedge prog_clk);
         if (acc) begin
            idx++;
            wt = 0;
         end
         if (done_cyc >= 0 || c == rst_cyc) break;
      end
      start = 1'b0; abort = 1'b0; pReset = 1'b0; word_valid = 1'b0;
   endtask

   task automatic set_words(input logic [7:0] a, b, c, d, input int g);
      wq[0] = a; wq[1] = b; wq[2] = c; wq[3] = d;
      gq[0] = 0; gq[1] = g; gq[2] = g; gq[3] = g;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge prog_clk);
      @(negedge prog_clk);
      total++; if ({busy, done, error, config_enable} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, config_enable}); else passed++;
      total++; if ({word_ready, ccff_head} !== 2'b0) $display("FAIL reset_ready_head: got %b expected 00", {word_ready, ccff_head}); else passed++;
      total++; if (bit_count !== '0) $display("FAIL reset_bit_count: got %0d expected 0", bit_count); else passed++;
      total++; if ({busy1, done1, err1, en1} !== 4'b0) $display("FAIL reset_len1: got %b expected 0000", {busy1, done1, err1, en1}); else passed++;
      pReset = 1'b0;
   endtask

   task automatic test_basic();
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h12, 0);
      drive(300);
      total++; if (done_cyc != 67) $display("FAIL basic_done_cycle: got %0d expected 67", done_cyc); else passed++;
      total++; if (err_done !== 1'b0) $display("FAIL basic_error: got %b expected 0", err_done); else passed++;
      total++; if (en_cnt != 2 * L) $display("FAIL basic_enable_cycles: got %0d expected %0d", en_cnt, 2 * L); else passed++;
      total++; if (chain !== exp_chain()) $display("FAIL basic_chain: got %h expected %h", chain, exp_chain()); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL basic_busy_after_done: got %b expected 0", busy); else passed++;
   endtask

   task automatic test_gaps();
      chain = '0;
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h12, 5);
      drive(300);
      total++; if (done_cyc != 82) $display("FAIL gaps_done_cycle: got %0d expected 82", done_cyc); else passed++;
      total++; if (err_done !== 1'b0) $display("FAIL gaps_error: got %b expected 0", err_done); else passed++;
      total++; if (en_cnt != 2 * L) $display("FAIL gaps_enable_cycles: got %0d expected %0d", en_cnt, 2 * L); else passed++;
      total++; if (chain !== exp_chain()) $display("FAIL gaps_chain: got %h expected %h", chain, exp_chain()); else passed++;
   endtask

   task automatic test_fault();
      fault = 1'b1;
      set_words(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
      drive(300);
      fault = 1'b0;
      total++; if (done_cyc != 67) $display("FAIL fault_done_cycle: got %0d expected 67", done_cyc); else passed++;
      total++; if (err_done !== 1'b1) $display("FAIL fault_error: got %b expected 1", err_done); else passed++;
   endtask

   task automatic test_abort();
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h12, 0);
      abort_cyc = 15;
      drive(300);
      abort_cyc = -1;
      total++; if (en_abort !== 1'b0) $display("FAIL abort_enable: got %b expected 0", en_abort); else passed++;
      total++; if (done_cyc != 16) $display("FAIL abort_done_cycle: got %0d expected 16", done_cyc); else passed++;
      total++; if (err_done !== 1'b1) $display("FAIL abort_error: got %b expected 1", err_done); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy_after: got %b expected 0", busy); else passed++;
      set_words(8'h5A, 8'hC3, 8'h00, 8'hE7, 0);
      drive(300);
      total++; if (err_c1 !== 1'b0) $display("FAIL restart_error_cleared: got %b expected 0", err_c1); else passed++;
      total++; if (done_cyc != 67) $display("FAIL restart_done_cycle: got %0d expected 67", done_cyc); else passed++;
      total++; if (err_done !== 1'b0) $display("FAIL restart_error: got %b expected 0", err_done); else passed++;
      total++; if (chain !== exp_chain()) $display("FAIL restart_chain: got %h expected %h", chain, exp_chain()); else passed++;
   endtask

   task automatic test_start_ignored();
      set_words(8'h96, 8'h0F, 8'h71, 8'hB4, 0);
      spam = 1;
      drive(300);
      spam = 0;
      total++; if (done_cyc != 67) $display("FAIL spam_done_cycle: got %0d expected 67", done_cyc); else passed++;
      total++; if (en_cnt != 2 * L) $display("FAIL spam_enable_cycles: got %0d expected %0d", en_cnt, 2 * L); else passed++;
      total++; if (chain !== exp_chain()) $display("FAIL spam_chain: got %h expected %h", chain, exp_chain()); else passed++;
   endtask

   task automatic test_reset_mid_verify();
      int en_after;
      set_words(8'hA5, 8'h3C, 8'hFF, 8'h12, 0);
      rst_cyc = 40;
      drive(300);
      rst_cyc = -1;
      total++; if ({busy, done, error, config_enable, word_ready, ccff_head} !== 6'b0) $display("FAIL midrst_outputs: got %b expected 000000", {busy, done, error, config_enable, word_ready, ccff_head}); else passed++;
      total++; if (bit_count !== '0) $display("FAIL midrst_bit_count: got %0d expected 0", bit_count); else passed++;
      en_after = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge prog_clk);
         if (config_enable || busy) en_after++;
      end
      total++; if (en_after != 0) $display("FAIL midrst_idle_after: got %0d active cycles expected 0", en_after); else passed++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int exp_done;
         for (int i = 0; i < 4; i++) begin
            wq[i] = 8'($urandom);
            gq[i] = $urandom_range(0, 3);
         end
         exp_done = 1 + 4 + 2 * L + gq[0] + gq[1] + gq[2] + gq[3];
         drive(300);
         total++; if (done_cyc != exp_done) $display("FAIL rand%0d_done_cycle: got %0d expected %0d", r, done_cyc, exp_done); else passed++;
         total++; if (err_done !== 1'b0) $display("FAIL rand%0d_error: got %b expected 0", r, err_done); else passed++;
         total++; if (en_cnt != 2 * L) $display("FAIL rand%0d_enable_cycles: got %0d expected %0d", r, en_cnt, 2 * L); else passed++;
         total++; if (chain !== exp_chain()) $display("FAIL rand%0d_chain: got %h expected %h", r, chain, exp_chain()); else passed++;
      end
   endtask

   task automatic test_chain_len1();
      int dc, ec;
      logic e;
      dc = -1; ec = 0; e = 1'bx;
      valid1 = 1'b1;
      @(negedge prog_clk);
      for (int c = 0; c < 20; c++) begin
         start1 = (c == 0);
         #1;
         if (en1) ec++;
         if (done1) begin
            dc = c;
            e  = err1;
         end
         @(negedge prog_clk);
         if (dc >= 0) break;
      end
      start1 = 1'b0; valid1 = 1'b0;
      total++; if (dc != 4) $display("FAIL len1_done_cycle: got %0d expected 4", dc); else passed++;
      total++; if (e !== 1'b0) $display("FAIL len1_error: got %b expected 0", e); else passed++;
      total++; if (ec != 2) $display("FAIL len1_enable_cycles: got %0d expected 2", ec); else passed++;
      total++; if (chain1 !== 1'b1) $display("FAIL len1_chain: got %b expected 1", chain1); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_fault();
      test_abort();
      test_start_ignored();
      test_reset_mid_verify();
      test_random();
      test_chain_len1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
